// File: rtl/r2sdf_stage.sv
// r2sdf_stage: radix-2 single-path delay-feedback FFT stage with input handshake and end-of-stream drain.
// Optional -j rotation of upper-half differences when R2SDF_NEG_J_EN is defined (needs DEPTH >= 2).
module r2sdf_stage #(
    parameter int IN_W  = 17,
    parameter int DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic signed [IN_W-1:0] data_in_r,
    input  logic signed [IN_W-1:0] data_in_i,
    output logic                   valid_o,
    output logic signed [IN_W:0]   data_out_r,
    output logic signed [IN_W:0]   data_out_i
);
    localparam int OW = IN_W + 1;
    localparam int CW = $clog2(2 * DEPTH);

`ifdef R2SDF_NEG_J_EN
    if (DEPTH < 2) begin : g_depth_err
        $error("r2sdf_stage: R2SDF_NEG_J_EN requires DEPTH >= 2");
    end
`endif

    typedef enum logic {RUN, DRAIN} state_t;
    state_t state_q, state_d;

    logic                   valid_in_q, valid_in_d;
    logic signed [IN_W-1:0] in_r_q, in_r_d, in_i_q, in_i_d;
    logic                   ready_q, ready_d;
    logic [CW-1:0]          cnt_q, cnt_d, dcnt_q, dcnt_d;
    logic                   pend_q, pend_d;
    logic signed [OW-1:0]   line_r_q [DEPTH];
    logic signed [OW-1:0]   line_r_d [DEPTH];
    logic signed [OW-1:0]   line_i_q [DEPTH];
    logic signed [OW-1:0]   line_i_d [DEPTH];
    logic                   valid_o_q, valid_o_d;
    logic signed [OW-1:0]   out_r_q, out_r_d, out_i_q, out_i_d;

    logic                   consume, drain, fill, last_drain, shift;
    logic signed [OW-1:0]   a_r, a_i, b_r, b_i, sum_r, sum_i, dif_r, dif_i, emit_r, emit_i;

    assign consume    = (state_q == RUN) && valid_in_q;
    assign drain      = (state_q == DRAIN);
    assign fill       = cnt_q < CW'(DEPTH);
    assign last_drain = drain && (dcnt_q == CW'(DEPTH - 1));
    assign shift      = consume || drain;
    assign a_r        = {in_r_q[IN_W-1], in_r_q};
    assign a_i        = {in_i_q[IN_W-1], in_i_q};
    assign b_r        = line_r_q[DEPTH-1];
    assign b_i        = line_i_q[DEPTH-1];
    assign sum_r      = b_r + a_r;
    assign sum_i      = b_i + a_i;
    assign dif_r      = b_r - a_r;
    assign dif_i      = b_i - a_i;

`ifdef R2SDF_NEG_J_EN
    logic [CW-1:0] k;
    logic          rot;
    // k is the difference index: the fill slot while streaming, the drain step while draining
    assign k      = drain ? dcnt_q : cnt_q;
    assign rot    = k >= CW'(DEPTH / 2);
    assign emit_r = rot ? b_i : b_r;
    assign emit_i = rot ? -b_r : b_i;
`else
    assign emit_r = b_r;
    assign emit_i = b_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == RUN) ? ((cnt_q == '0 && pend_q && !valid_in_q) ? DRAIN : RUN)
                                   : (last_drain ? RUN : DRAIN);
    end

    always_comb begin
        ready_d    = (state_d == RUN);
        valid_in_d = ready_q ? valid_i : valid_in_q;
        in_r_d     = ready_q ? data_in_r : in_r_q;
        in_i_d     = ready_q ? data_in_i : in_i_q;
        cnt_d      = consume ? cnt_q + CW'(1) : cnt_q;
        dcnt_d     = (drain && !last_drain) ? dcnt_q + CW'(1) : '0;
        pend_d     = (consume && cnt_q == CW'(2 * DEPTH - 1)) ? 1'b1 :
                     ((consume && cnt_q == CW'(DEPTH - 1)) || last_drain) ? 1'b0 : pend_q;
        valid_o_d  = drain || (consume && (!fill || pend_q));
        out_r_d    = !valid_o_d ? out_r_q : (consume && !fill) ? sum_r : emit_r;
        out_i_d    = !valid_o_d ? out_i_q : (consume && !fill) ? sum_i : emit_i;
        // fill writes the sample, the butterfly half writes B-A, draining backfills zeros
        line_r_d[0] = !shift ? line_r_q[0] : drain ? '0 : fill ? a_r : dif_r;
        line_i_d[0] = !shift ? line_i_q[0] : drain ? '0 : fill ? a_i : dif_i;
        for (int j = 1; j < DEPTH; j++) begin
            line_r_d[j] = shift ? line_r_q[j-1] : line_r_q[j];
            line_i_d[j] = shift ? line_i_q[j-1] : line_i_q[j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= 1'b1;
            valid_in_q <= 1'b0;
            in_r_q     <= '0;
            in_i_q     <= '0;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            pend_q     <= 1'b0;
            line_r_q   <= '{default: '0};
            line_i_q   <= '{default: '0};
            valid_o_q  <= 1'b0;
            out_r_q    <= '0;
            out_i_q    <= '0;
        end else begin
            ready_q    <= ready_d;
            valid_in_q <= valid_in_d;
            in_r_q     <= in_r_d;
            in_i_q     <= in_i_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            pend_q     <= pend_d;
            line_r_q   <= line_r_d;
            line_i_q   <= line_i_d;
            valid_o_q  <= valid_o_d;
            out_r_q    <= out_r_d;
            out_i_q    <= out_i_d;
        end
    end

    assign ready_o    = ready_q;
    assign valid_o    = valid_o_q;
    assign data_out_r = out_r_q;
    assign data_out_i = out_i_q;
endmodule
